uart_tx_fsm: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_baud_cnt.sv | 48 ++++
 rtl/uart_tx_fsm.sv | 117 +++++++++++
 tb/tb_uart_tx_fsm.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and
// parity-type encodings used by par_typ.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b010,
        PARITY = 3'b011,
        STOP   = 3'b110
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Bit-timing counters for the UART transmitter. edge_cnt counts clk cycles
// inside one bit period, bit_cnt counts bits inside the DATA or STOP phase.
// Optional macro UART_TX_TWO_STOP_EN: stop phase spans two bit periods.
module uart_tx_baud_cnt #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6,
    localparam int BIT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,         // frame in progress
    input  logic                  cnt_bits,    // current phase counts bits
    input  logic                  phase_last,  // current bit is the phase's last
    input  logic [PRESCALE_W-1:0] presc,       // latched cycles per bit, >= 1
    output logic                  bit_done,    // last cycle of the current bit
    output logic                  last_data,   // on the final data bit
    output logic                  last_stop    // on the final stop bit
);

    localparam logic [PRESCALE_W-1:0] P_ONE = PRESCALE_W'(1);
    localparam logic [BIT_W-1:0]      B_ONE = BIT_W'(1);

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_W-1:0]      bit_cnt;

    assign bit_done  = (edge_cnt == presc - P_ONE);
    assign last_data = (bit_cnt == BIT_W'(DATA_W - 1));
`ifdef UART_TX_TWO_STOP_EN
    assign last_stop = (bit_cnt == B_ONE);
`else
    assign last_stop = 1'b1;
`endif

    // Cycle counter wraps at each bit boundary; bit counter restarts at the
    // end of each phase so it is already zero when the next phase begins.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (bit_done) begin
            edge_cnt <= '0;
            bit_cnt  <= (cnt_bits && !phase_last) ? bit_cnt + B_ONE : '0;
        end else begin
            edge_cnt <= edge_cnt + P_ONE;
        end
    end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit controller: latches a byte on data_valid && tx_ready and
// shifts it out LSB-first as start, data, optional parity and stop bits.
// Optional macro UART_TX_TWO_STOP_EN: two stop bits per frame.
module uart_tx_fsm
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     P_DATA,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  tx_ready
);

    localparam logic [PRESCALE_W-1:0] P_ONE = PRESCALE_W'(1);

    state_t                state;
    logic [DATA_W-1:0]     data_sh;    // remaining data bits, current at [0]
    logic                  par_q;
    logic                  par_bit_q;
    logic [PRESCALE_W-1:0] presc_q;

    logic                  bit_done;
    logic                  last_data;
    logic                  last_stop;
    logic                  stop_end;
    logic                  accept;
    logic [PRESCALE_W-1:0] presc_eff;
    logic                  par_new;

    // A prescale of zero would never finish a bit, so it runs as one.
    assign presc_eff = (prescale == '0) ? P_ONE : prescale;
    assign par_new   = (^P_DATA) ^ (par_typ == PAR_ODD);
    assign stop_end  = (state == STOP) && bit_done && last_stop;
    assign tx_ready  = (state == IDLE) || stop_end;
    assign accept    = data_valid && tx_ready;

    uart_tx_baud_cnt #(
        .DATA_W     (DATA_W),
        .PRESCALE_W (PRESCALE_W)
    ) u_baud (
        .clk        (clk),
        .rst        (rst),
        .run        (state != IDLE),
        .cnt_bits   ((state == DATA) || (state == STOP)),
        .phase_last ((state == DATA) ? last_data : last_stop),
        .presc      (presc_q),
        .bit_done   (bit_done),
        .last_data  (last_data),
        .last_stop  (last_stop)
    );

    // Frame sequencer; TX_OUT and busy are registered with the state so the
    // line level always matches the bit the counters are timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            TX_OUT    <= 1'b1;
            busy      <= 1'b0;
            data_sh   <= '0;
            par_q     <= 1'b0;
            par_bit_q <= 1'b0;
            presc_q   <= P_ONE;
        end else if (accept) begin
            // Shadow all frame parameters so later input changes are ignored.
            data_sh   <= P_DATA;
            par_q     <= par_en;
            par_bit_q <= par_new;
            presc_q   <= presc_eff;
            state     <= START;
            TX_OUT    <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                IDLE: ;
                START: if (bit_done) begin
                    state  <= DATA;
                    TX_OUT <= data_sh[0];
                end
                DATA: if (bit_done) begin
                    if (!last_data) begin
                        data_sh <= data_sh >> 1;
                        TX_OUT  <= data_sh[1];
                    end else if (par_q) begin
                        state  <= PARITY;
                        TX_OUT <= par_bit_q;
                    end else begin
                        state  <= STOP;
                        TX_OUT <= 1'b1;
                    end
                end
                PARITY: if (bit_done) begin
                    state  <= STOP;
                    TX_OUT <= 1'b1;
                end
                STOP: if (stop_end) begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Scoreboard bench for uart_tx_fsm: each accepted frame pushes its expected
// per-cycle line levels; a negedge monitor pops one level per busy cycle.
module tb_uart_tx_fsm;

`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] P_DATA = 8'h00;
    logic       data_valid = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [5:0] prescale = 6'd8;
    logic       TX_OUT;
    logic       busy;
    logic       tx_ready;

    int   n_chk  = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;
    logic sb[$];

    uart_tx_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy),
        .tx_ready   (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Expected line level for every cycle of one frame.
    task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt, input int p);
        int pp;
        pp = (p == 0) ? 1 : p;
        for (int c = 0; c < pp; c++) sb.push_back(1'b0);
        for (int b = 0; b < 8; b++)
            for (int c = 0; c < pp; c++) sb.push_back(d[b]);
        if (pe)
            for (int c = 0; c < pp; c++) sb.push_back((^d) ^ pt);
        for (int c = 0; c < NSTOP * pp; c++) sb.push_back(1'b1);
    endtask

    // Present a byte to an idle DUT for one cycle; called just after a posedge.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input int p);
        P_DATA     = d;
        par_en     = pe;
        par_typ    = pt;
        prescale   = 6'(p);
        data_valid = 1'b1;
        push_frame(d, pe, pt, p);
        @(posedge clk); #1;
        data_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk({tag, "_timeout"}, busy, 0);
        chk({tag, "_left"}, sb.size(), 0);
        sb.delete();
        @(posedge clk); #1;
    endtask

    // One expected level per busy cycle; idle line must be high and ready.
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) begin
                if (sb.size() == 0) chk("frame_len", busy, 0);
                else chk("tx_bit", TX_OUT, sb.pop_front());
            end else begin
                chk("idle_line", TX_OUT, 1);
                chk("idle_ready", tx_ready, 1);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", TX_OUT, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", tx_ready, 1);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Plain frame, then parity variants.
        send(8'hA5, 1'b0, 1'b0, 8);  wait_idle("a5_nopar");
        send(8'hA5, 1'b1, 1'b0, 8);  wait_idle("a5_even");
        send(8'hA5, 1'b1, 1'b1, 8);  wait_idle("a5_odd");
        send(8'h07, 1'b1, 1'b0, 8);  wait_idle("07_even");

        // Back-to-back: valid held across the end of the first frame.
        P_DATA = 8'h55; par_en = 1'b0; prescale = 6'd4; data_valid = 1'b1;
        push_frame(8'h55, 1'b0, 1'b0, 4);
        @(posedge clk); #1;
        P_DATA = 8'h0F;
        push_frame(8'h0F, 1'b0, 1'b0, 4);
        repeat ((9 + NSTOP) * 4) @(posedge clk);
        #1;
        data_valid = 1'b0;
        wait_idle("b2b");

        // Mid-frame strobe must be dropped.
        send(8'hA5, 1'b0, 1'b0, 8);
        repeat (20) @(posedge clk);
        #1;
        P_DATA = 8'hFF; data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        wait_idle("drop");

        // Reset during data bit 3 aborts the frame.
        send(8'h96, 1'b0, 1'b0, 8);
        repeat (34) @(posedge clk);
        #1;
        mon_en = 1'b0;
        sb.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_tx", TX_OUT, 1);
        chk("abort_busy", busy, 0);
        chk("abort_ready", tx_ready, 1);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;
        send(8'h3C, 1'b0, 1'b0, 8);  wait_idle("3c_after_rst");

        // Prescale change mid-frame only affects the next frame.
        send(8'hA5, 1'b1, 1'b1, 8);
        prescale = 6'd16;
        wait_idle("presc_hold");
        send(8'h5A, 1'b0, 1'b0, 16); wait_idle("presc16");
        send(8'hC3, 1'b1, 1'b0, 0);  wait_idle("presc0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
